id_ex_pipeline_register: RTL and testbench

Registered ID/EX boundary of the segmented RISC-V core. It captures the decoded operands, the immediate, the instruction fields and the control bundle produced in ID, and presents them to EX one cycle later. It supports downstream stall (hold), branch/jump flush (bubble), and built-in load-use hazard detection that inserts exactly one bubble. It also drives the stall request back to the PC and IF/ID stages.

---
 rtl/id_ex_pipeline_register.sv | 111 +++++++++++
 tb/tb_id_ex_pipeline_register.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register: ID/EX boundary register with stall, flush and load-use bubble insertion
//   Inputs : clk, rst_n (async active-low), stall, flush, valid_in, pc_in, read_data_1_in,
//            read_data_2_in, immediate_gen_in, instruction_in, instruction_11_7_in,
//            instruction_14_12_in, instruction_30_in, ctrl_in, if_id_rs1, if_id_rs2, if_id_uses_rs2
//   Outputs: registered copies of every *_in field (*_out), valid_out, ctrl_out,
//            load_use_stall (combinational hazard request to PC and IF/ID)
//   Option : define ID_EX_BUBBLE_COUNT_EN to add a saturating 16-bit bubble_count output
module id_ex_pipeline_register #(
  parameter int          XLEN     = 32,
  parameter int          CTRL_W   = 12,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   read_data_1_in,
  input  logic [XLEN-1:0]   read_data_2_in,
  input  logic [XLEN-1:0]   immediate_gen_in,
  input  logic [31:0]       instruction_in,
  input  logic [4:0]        instruction_11_7_in,
  input  logic [2:0]        instruction_14_12_in,
  input  logic              instruction_30_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic              if_id_uses_rs2,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   read_data_1_out,
  output logic [XLEN-1:0]   read_data_2_out,
  output logic [XLEN-1:0]   immediate_gen_out,
  output logic [31:0]       instruction_out,
  output logic [4:0]        instruction_11_7_out,
  output logic [2:0]        instruction_14_12_out,
  output logic              instruction_30_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
`ifdef ID_EX_BUBBLE_COUNT_EN
  output logic [15:0]       bubble_count,
`endif
  output logic              load_use_stall
);
  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_imm;
  logic [31:0]       r_insn;
  logic [4:0]        r_rd;
  logic [2:0]        r_f3;
  logic              r_f7b5;
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_ex_is_load;
  logic              w_hazard;
  logic              w_bubble;

  assign w_ex_is_load = r_valid && r_insn[6:0] == 7'b0000011;
  assign w_hazard     = w_ex_is_load && r_rd != 5'd0 &&
                        (r_rd == if_id_rs1 || (if_id_uses_rs2 && r_rd == if_id_rs2));
  // Flush beats stall; a load-use bubble only happens when downstream is not holding.
  assign w_bubble     = flush || (!stall && w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_insn  <= NOP_INSN;
      r_rd    <= '0;
      r_f3    <= '0;
      r_f7b5  <= 1'b0;
      r_ctrl  <= '0;
    end else if (!stall) begin
      r_valid <= valid_in;
      r_pc    <= pc_in;
      r_rd1   <= read_data_1_in;
      r_rd2   <= read_data_2_in;
      r_imm   <= immediate_gen_in;
      r_insn  <= instruction_in;
      r_rd    <= instruction_11_7_in;
      r_f3    <= instruction_14_12_in;
      r_f7b5  <= instruction_30_in;
      r_ctrl  <= ctrl_in;
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] r_bubble_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bubble_count <= '0;
    else if (w_bubble && r_bubble_count != 16'hFFFF) r_bubble_count <= r_bubble_count + 16'd1;
  end
  assign bubble_count = r_bubble_count;
`endif

  assign valid_out             = r_valid;
  assign pc_out                = r_pc;
  assign read_data_1_out       = r_rd1;
  assign read_data_2_out       = r_rd2;
  assign immediate_gen_out     = r_imm;
  assign instruction_out       = r_insn;
  assign instruction_11_7_out  = r_rd;
  assign instruction_14_12_out = r_f3;
  assign instruction_30_out    = r_f7b5;
  assign ctrl_out              = r_ctrl;
  assign load_use_stall        = w_hazard;
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb_id_ex_pipeline_register: directed bench for the ID/EX pipeline register
module tb_id_ex_pipeline_register;
  logic        clk = 1'b0;
  logic        rst_n, stall, flush, valid_in, instruction_30_in, if_id_uses_rs2;
  logic [31:0] pc_in, read_data_1_in, read_data_2_in, immediate_gen_in, instruction_in;
  logic [4:0]  instruction_11_7_in, if_id_rs1, if_id_rs2;
  logic [2:0]  instruction_14_12_in;
  logic [11:0] ctrl_in;
  logic [31:0] pc_out, read_data_1_out, read_data_2_out, immediate_gen_out, instruction_out;
  logic [4:0]  instruction_11_7_out;
  logic [2:0]  instruction_14_12_out;
  logic        instruction_30_out, valid_out, load_use_stall;
  logic [11:0] ctrl_out;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .read_data_1_in(read_data_1_in), .read_data_2_in(read_data_2_in),
    .immediate_gen_in(immediate_gen_in), .instruction_in(instruction_in),
    .instruction_11_7_in(instruction_11_7_in), .instruction_14_12_in(instruction_14_12_in),
    .instruction_30_in(instruction_30_in), .ctrl_in(ctrl_in),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .pc_out(pc_out), .read_data_1_out(read_data_1_out), .read_data_2_out(read_data_2_out),
    .immediate_gen_out(immediate_gen_out), .instruction_out(instruction_out),
    .instruction_11_7_out(instruction_11_7_out), .instruction_14_12_out(instruction_14_12_out),
    .instruction_30_out(instruction_30_out), .ctrl_out(ctrl_out), .valid_out(valid_out),
`ifdef ID_EX_BUBBLE_COUNT_EN
    .bubble_count(bubble_count),
`endif
    .load_use_stall(load_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic v);
    pc_in = pc; instruction_in = insn; read_data_1_in = rd1; read_data_2_in = rd2;
    immediate_gen_in = 32'h0; valid_in = v; ctrl_in = 12'h0A5;
    instruction_11_7_in = insn[11:7]; instruction_14_12_in = insn[14:12]; instruction_30_in = insn[30];
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; if_id_uses_rs2 = 1'b0;
    drive(32'h100, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    @(negedge clk);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_insn", instruction_out, 32'h00000013);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_ctrl", {20'b0, ctrl_out}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("flow_pc", pc_out, 32'h100);
    chk("flow_rd", {27'b0, instruction_11_7_out}, 32'd3);
    chk("flow_f3", {29'b0, instruction_14_12_out}, 32'd0);
    chk("flow_rd1", read_data_1_out, 32'd5);
    chk("flow_rd2", read_data_2_out, 32'd7);
    chk("flow_valid", {31'b0, valid_out}, 32'd1);
    chk("flow_ctrl", {20'b0, ctrl_out}, 32'h0A5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, valid_out}, 32'd0);
    chk("async_rst_insn", instruction_out, 32'h00000013);
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(32'h104, 32'h0000A283, 32'd1, 32'd0, 1'b1);
    step();
    chk("lw_f3", {29'b0, instruction_14_12_out}, 32'd2);
    drive(32'h108, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    if_id_rs1 = 5'd5;
    #1 chk("lu_stall_on", {31'b0, load_use_stall}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'b0, valid_out}, 32'd0);
    chk("lu_bubble_insn", instruction_out, 32'h00000013);
    chk("lu_bubble_pc", pc_out, 32'h0);
    chk("lu_stall_off", {31'b0, load_use_stall}, 32'd0);
    step();
    chk("lu_retry_pc", pc_out, 32'h108);
    chk("lu_retry_valid", {31'b0, valid_out}, 32'd1);
    drive(32'h10C, 32'h0000A003, 32'd0, 32'd0, 1'b1);
    step();
    if_id_rs1 = 5'd0;
    #1 chk("lu_x0", {31'b0, load_use_stall}, 32'd0);
    drive(32'h110, 32'h0000A303, 32'd0, 32'd0, 1'b1);
    step();
    if_id_rs1 = 5'd1; if_id_rs2 = 5'd6; if_id_uses_rs2 = 1'b1;
    #1 chk("rs2_used", {31'b0, load_use_stall}, 32'd1);
    if_id_uses_rs2 = 1'b0;
    #1 chk("rs2_unused", {31'b0, load_use_stall}, 32'd0);
    drive(32'h200, 32'h002081B3, 32'd9, 32'd7, 1'b1);
    step();
    chk("pre_stall_pc", pc_out, 32'h200);
    stall = 1'b1;
    drive(32'h300, 32'h40208233, 32'd1, 32'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc_out, 32'h200);
      chk("stall_rd1", read_data_1_out, 32'd9);
      chk("stall_valid", {31'b0, valid_out}, 32'd1);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {31'b0, valid_out}, 32'd0);
    chk("flush_insn", instruction_out, 32'h00000013);
    chk("flush_pc", pc_out, 32'h0);
    flush = 1'b0; stall = 1'b0;
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
    drive(32'h120, 32'h0000A283, 32'd0, 32'd0, 1'b1);
    step();
    stall = 1'b1; if_id_rs1 = 5'd5;
    step();
    chk("stall_hazard_req", {31'b0, load_use_stall}, 32'd1);
    chk("stall_hazard_hold", instruction_out, 32'h0000A283);
    stall = 1'b0;
    step();
    chk("hazard_after_stall", {31'b0, valid_out}, 32'd0);
    if_id_rs1 = 5'd0;
    drive(32'h400, 32'h002081B3, 32'd3, 32'd4, 1'b0);
    step();
    chk("invalid_pc", pc_out, 32'h400);
    chk("invalid_valid", {31'b0, valid_out}, 32'd0);
    chk("invalid_f7b5", {31'b0, instruction_30_out}, 32'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    chk("bubble_count_3", {16'b0, bubble_count}, 32'd3);
    flush = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("bubble_count_sat", {16'b0, bubble_count}, 32'h0000FFFF);
    flush = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
